// File: rtl/pwm_load_sequencer.sv
// ---------------------------------------------------------------------------
// pwm_load_sequencer
//
// Frames the update of PWM channel setpoints. Software-side writes land in
// per-channel shadow registers and mark the channel dirty. Once per load
// frame (DIV core cycles) a one-cycle COMMIT state copies every dirty shadow
// into the active A/B outputs, enables those channels, and the following
// cycle raises a single-cycle load strobe aligned with the new values.
// A stop request lets the current frame run out (DRAIN) without committing,
// then drops all channel enables and returns to IDLE.
//
// Parameters
//   NCH     number of PWM channels sequenced
//   DIV     core cycles per load frame, legal range 4..65535
//   W       width of each A/B value
//
// Ports
//   clkCore   in   core clock, all logic on the rising edge
//   reset     in   synchronous, active-low reset
//   start     in   level, begin framed operation (ignored while stop=1)
//   stop      in   level, finish at the next frame boundary
//   wr_valid  in   setpoint write request
//   wr_ready  out  setpoint write accept (low only in COMMIT)
//   wr_ch     in   target channel index
//   wr_a      in   requested A value (reset-edge period count)
//   wr_b      in   requested B value (set-edge period count)
//   wr_err    out  one-cycle pulse, previous accepted write was rejected
//   load      out  one-cycle load strobe to the channel counters
//   en        out  per-channel counter enable
//   A_val     out  active A values, channel k at [k*W +: W]
//   B_val     out  active B values, same packing
//   busy      out  high in any state other than IDLE
// ---------------------------------------------------------------------------
module pwm_load_sequencer #(
    parameter int NCH = 4,
    parameter int DIV = 200,
    parameter int W   = 7,
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clkCore,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [CHW-1:0]   wr_ch,
    input  logic [W-1:0]     wr_a,
    input  logic [W-1:0]     wr_b,
    output logic             wr_err,
    output logic             load,
    output logic [NCH-1:0]   en,
    output logic [NCH*W-1:0] A_val,
    output logic [NCH*W-1:0] B_val,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        COMMIT,
        DRAIN
    } state_t;

    // Last count of a frame; the counter wraps from here back to 0.
    localparam logic [15:0]  FCNT_LAST = 16'(DIV - 1);
    // One extra bit so the range check also works for power-of-two NCH.
    localparam logic [CHW:0] CH_LIMIT  = (CHW + 1)'(NCH);

    state_t         state;
    logic [15:0]    fcnt;
    logic [15:0]    fcnt_inc;
    logic           frame_last;
    logic           wr_fire;
    logic           wr_bad;

    logic [W-1:0]   shadow_a [NCH];
    logic [W-1:0]   shadow_b [NCH];
    logic [NCH-1:0] dirty;

    // Handshake and status are plain decodes of the state register, so they
    // are glitch-free and valid on the very first cycle after reset.
    assign wr_ready = (state != COMMIT);
    assign busy     = (state != IDLE);

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        frame_last = 1'b0;
        fcnt_inc   = '0;
        wr_fire    = 1'b0;
        wr_bad     = 1'b0;

        frame_last = (fcnt == FCNT_LAST);
        fcnt_inc   = frame_last ? 16'd0 : fcnt + 16'd1;
        wr_fire    = wr_valid && wr_ready;
        wr_bad     = ({1'b0, wr_ch} >= CH_LIMIT) || (wr_a == '0) || (wr_b == '0);
    end

    // -----------------------------------------------------------------------
    // Sequencer: state, frame counter and the registered load strobe.
    // COMMIT always lands on fcnt==0 because RUN only leaves for COMMIT on
    // the wrapping count.
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop regardless of the
    // order of statements or blocks.
    always_ff @(posedge clkCore) begin
        if (!reset) begin
            state <= IDLE;
            fcnt  <= '0;
            load  <= 1'b0;
        end else begin
            // Strobe follows the COMMIT cycle, matching the A/B update edge.
            load <= (state == COMMIT);

            unique case (state)
                IDLE: begin
                    fcnt <= '0;
                    if (start && !stop) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    fcnt <= fcnt_inc;
                    if (stop) begin
                        state <= DRAIN;
                    end else if (frame_last) begin
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    fcnt  <= fcnt_inc;
                    state <= stop ? DRAIN : RUN;
                end
                DRAIN: begin
                    fcnt <= fcnt_inc;
                    if (frame_last) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    fcnt  <= '0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Setpoint path: shadow capture on accepted writes, commit of dirty
    // channels in COMMIT, enable teardown at the end of DRAIN.
    // Writes and commits never collide: wr_ready is low during COMMIT, so a
    // write accepted on the last RUN cycle is already in the shadow when the
    // commit samples it.
    // -----------------------------------------------------------------------
    always_ff @(posedge clkCore) begin
        if (!reset) begin
            // NOTE: the shadow arrays are reset explicitly because a reset
            // must also discard any pending, uncommitted setpoints; plain
            // storage without that need would be left unreset.
            for (int k = 0; k < NCH; k++) begin
                shadow_a[k] <= '0;
                shadow_b[k] <= '0;
            end
            dirty  <= '0;
            wr_err <= 1'b0;
            en     <= '0;
            A_val  <= '0;
            B_val  <= '0;
        end else begin
            wr_err <= wr_fire && wr_bad;

            // Later writes simply overwrite the shadow: last write wins.
            if (wr_fire && !wr_bad) begin
                shadow_a[wr_ch] <= wr_a;
                shadow_b[wr_ch] <= wr_b;
                dirty[wr_ch]    <= 1'b1;
            end

            if (state == COMMIT) begin
                for (int k = 0; k < NCH; k++) begin
                    if (dirty[k]) begin
                        A_val[k*W +: W] <= shadow_a[k];
                        B_val[k*W +: W] <= shadow_b[k];
                        en[k]           <= 1'b1;
                        dirty[k]        <= 1'b0;
                    end
                end
            end else if ((state == DRAIN) && frame_last) begin
                // Active values are kept; only the counters are stopped.
                // Dirty bits survive so a restart commits them.
                en <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pwm_load_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pwm_load_sequencer
//
// Directed bench for pwm_load_sequencer with DIV=8, NCH=4, W=7, plus a small
// NCH=3 instance used only for the out-of-range channel rejection.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the
// same point, i.e. they show the effect of the edge just taken.
// ---------------------------------------------------------------------------
module tb_pwm_load_sequencer;

    localparam int NCH = 4;
    localparam int DIV = 8;
    localparam int W   = 7;

    logic clk_core = 1'b0;
    always #5 clk_core = ~clk_core;

    logic             rst_n;
    logic             start;
    logic             stop;
    logic             wr_valid;
    logic             wr_ready;
    logic [1:0]       wr_ch;
    logic [W-1:0]     wr_a;
    logic [W-1:0]     wr_b;
    logic             wr_err;
    logic             load;
    logic [NCH-1:0]   en;
    logic [NCH*W-1:0] a_val;
    logic [NCH*W-1:0] b_val;
    logic             busy;

    // Second instance, NCH=3, so channel 3 is representable but illegal.
    logic             wr_valid3;
    logic             wr_ready3;
    logic [1:0]       wr_ch3;
    logic [W-1:0]     wr_a3;
    logic [W-1:0]     wr_b3;
    logic             wr_err3;
    logic             load3;
    logic [2:0]       en3;
    logic [3*W-1:0]   a_val3;
    logic [3*W-1:0]   b_val3;
    logic             busy3;

    int total = 0;
    int bad   = 0;
    int lat;

    pwm_load_sequencer #(.NCH(NCH), .DIV(DIV), .W(W)) u_dut (
        .clkCore  (clk_core),
        .reset    (rst_n),
        .start    (start),
        .stop     (stop),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_ch    (wr_ch),
        .wr_a     (wr_a),
        .wr_b     (wr_b),
        .wr_err   (wr_err),
        .load     (load),
        .en       (en),
        .A_val    (a_val),
        .B_val    (b_val),
        .busy     (busy)
    );

    pwm_load_sequencer #(.NCH(3), .DIV(DIV), .W(W)) u_dut3 (
        .clkCore  (clk_core),
        .reset    (rst_n),
        .start    (1'b0),
        .stop     (1'b0),
        .wr_valid (wr_valid3),
        .wr_ready (wr_ready3),
        .wr_ch    (wr_ch3),
        .wr_a     (wr_a3),
        .wr_b     (wr_b3),
        .wr_err   (wr_err3),
        .load     (load3),
        .en       (en3),
        .A_val    (a_val3),
        .B_val    (b_val3),
        .busy     (busy3)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_core);
        #1;
    endtask

    task automatic drive_wr(input int ch, input int a, input int b);
        wr_valid = 1'b1;
        wr_ch    = 2'(ch);
        wr_a     = 7'(a);
        wr_b     = 7'(b);
    endtask

    // Steps until load is seen; returns the number of edges taken.
    task automatic run_to_load(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!load && n < 40);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"},  busy,     1'b0);
        check({tag, "_load"},  load,     1'b0);
        check({tag, "_err"},   wr_err,   1'b0);
        check({tag, "_en"},    en,       4'b0000);
        check({tag, "_a"},     a_val,    28'h0);
        check({tag, "_b"},     b_val,    28'h0);
        check({tag, "_ready"}, wr_ready, 1'b1);
    endtask

    function automatic logic [27:0] pack(input int v0, input int v1, input int v2, input int v3);
        return {7'(v3), 7'(v2), 7'(v1), 7'(v0)};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        wr_valid  = 1'b0;
        wr_ch     = '0;
        wr_a      = '0;
        wr_b      = '0;
        wr_valid3 = 1'b0;
        wr_ch3    = '0;
        wr_a3     = '0;
        wr_b3     = '0;

        // ---- reset state ----
        step();
        step();
        check_reset_state("rst");
        rst_n = 1'b1;

        // ---- basic frame: ch1 A=40 B=41 written in IDLE ----
        drive_wr(1, 40, 41);
        step();
        wr_valid = 1'b0;
        check("wr1_err", wr_err, 1'b0);
        check("wr1_idle_en", en, 4'b0000);
        start = 1'b1;
        step();                              // RUN, fcnt=0
        start = 1'b0;
        check("run_busy", busy, 1'b1);
        run_to_load(lat);                    // 7 + COMMIT + load
        check("first_load_lat", lat, 9);
        check("first_load_a", a_val, pack(0, 40, 0, 0));
        check("first_load_b", b_val, pack(0, 41, 0, 0));
        check("first_load_en", en, 4'b0010);
        step();
        check("load_one_cycle", load, 1'b0);
        run_to_load(lat);
        check("load_period", lat, DIV - 1);  // one step already taken
        check("period_en", en, 4'b0010);

        // ---- rejected writes: A=0, then B=0 (fcnt=1 now) ----
        drive_wr(2, 0, 5);
        step();                              // fcnt=2
        check("err_a0", wr_err, 1'b1);
        drive_wr(2, 5, 0);
        step();                              // fcnt=3
        check("err_b0", wr_err, 1'b1);
        wr_valid = 1'b0;
        step();                              // fcnt=4
        check("err_pulse_end", wr_err, 1'b0);
        run_to_load(lat);
        check("err_load_lat", lat, 5);
        check("err_no_change_a", a_val, pack(0, 40, 0, 0));
        check("err_no_change_en", en, 4'b0010);

        // ---- last write wins: ch2 A=10 then A=20 in one frame ----
        drive_wr(2, 10, 3);
        step();                              // fcnt=2
        drive_wr(2, 20, 4);
        step();                              // fcnt=3
        wr_valid = 1'b0;
        run_to_load(lat);
        check("lww_lat", lat, 6);
        check("lww_a", a_val, pack(0, 40, 20, 0));
        check("lww_b", b_val, pack(0, 41, 4, 0));
        check("lww_en", en, 4'b0110);

        // ---- write on fcnt=7, write held across COMMIT ----
        repeat (6) step();                   // fcnt=7
        drive_wr(3, 7, 9);
        check("f7_ready", wr_ready, 1'b1);
        step();                              // COMMIT, ch3 accepted
        check("commit_ready", wr_ready, 1'b0);
        check("commit_no_load", load, 1'b0);
        drive_wr(0, 1, 2);                   // offered during COMMIT
        step();                              // load cycle
        check("f7_load", load, 1'b1);
        check("f7_a", a_val, pack(0, 40, 20, 7));
        check("f7_b", b_val, pack(0, 41, 4, 9));
        check("f7_en", en, 4'b1110);
        check("post_commit_ready", wr_ready, 1'b1);
        step();                              // ch0 accepted, fcnt=2
        wr_valid = 1'b0;
        run_to_load(lat);
        check("held_lat", lat, 7);
        check("held_a", a_val, pack(1, 40, 20, 7));
        check("held_b", b_val, pack(2, 41, 4, 9));
        check("held_en", en, 4'b1111);

        // ---- stop at fcnt=3, write during DRAIN stays pending ----
        repeat (2) step();                   // fcnt=3
        stop  = 1'b1;
        start = 1'b1;
        step();                              // DRAIN, fcnt=4
        stop  = 1'b0;
        start = 1'b0;
        check("drain_busy", busy, 1'b1);
        check("drain_ready", wr_ready, 1'b1);
        drive_wr(1, 50, 51);
        step();                              // fcnt=5
        wr_valid = 1'b0;
        check("drain_wr_err", wr_err, 1'b0);
        step();                              // fcnt=6
        check("drain_no_load6", load, 1'b0);
        step();                              // fcnt=7
        check("drain_no_load7", load, 1'b0);
        check("drain_en_kept", en, 4'b1111);
        step();                              // IDLE
        check("drain_idle_busy", busy, 1'b0);
        check("drain_idle_en", en, 4'b0000);
        check("drain_idle_load", load, 1'b0);
        check("drain_no_commit_a", a_val, pack(1, 40, 20, 7));
        check("drain_no_commit_b", b_val, pack(2, 41, 4, 9));

        // ---- stop has priority over start in IDLE, then restart ----
        start = 1'b1;
        stop  = 1'b1;
        step();
        check("idle_stop_prio", busy, 1'b0);
        stop = 1'b0;
        step();                              // RUN, fcnt=0
        start = 1'b0;
        check("restart_busy", busy, 1'b1);
        run_to_load(lat);
        check("restart_lat", lat, 9);
        check("restart_a", a_val, pack(1, 50, 20, 7));
        check("restart_b", b_val, pack(2, 51, 4, 9));
        check("restart_en", en, 4'b0010);

        // ---- start re-asserted during RUN changes nothing ----
        start = 1'b1;
        run_to_load(lat);
        start = 1'b0;
        check("start_in_run_lat", lat, 8);
        check("start_in_run_en", en, 4'b0010);

        // ---- reset during COMMIT, pending ch3 write discarded ----
        drive_wr(3, 33, 34);
        step();                              // fcnt=2
        wr_valid = 1'b0;
        repeat (5) step();                   // fcnt=7
        step();                              // COMMIT
        check("pre_rst_commit", wr_ready, 1'b0);
        rst_n = 1'b0;
        step();
        check_reset_state("rst_commit");
        rst_n = 1'b1;
        start = 1'b1;
        step();                              // RUN, fcnt=0
        start = 1'b0;
        run_to_load(lat);
        check("post_rst_lat", lat, 9);
        check("post_rst_en", en, 4'b0000);
        check("post_rst_a", a_val, 28'h0);
        check("post_rst_b", b_val, 28'h0);

        // ---- reset during DRAIN with a rejected write in flight ----
        stop = 1'b1;
        step();                              // DRAIN, fcnt=2
        stop = 1'b0;
        check("pre_rst_drain", busy, 1'b1);
        step();                              // fcnt=3
        rst_n = 1'b0;
        drive_wr(0, 0, 1);
        step();
        check_reset_state("rst_drain");
        rst_n    = 1'b1;
        wr_valid = 1'b0;
        step();
        check("after_rst_idle", busy, 1'b0);

        // ---- channel range check on the NCH=3 build ----
        wr_valid3 = 1'b1;
        wr_ch3    = 2'd3;
        wr_a3     = 7'd5;
        wr_b3     = 7'd5;
        step();
        check("ch_range_err", wr_err3, 1'b1);
        wr_ch3 = 2'd2;
        step();
        check("ch_in_range_ok", wr_err3, 1'b0);
        wr_valid3 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
